// File: rtl/countdown_timer_8bit_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_8bit_pkg
// Shared definitions for the loadable down-counter:
//   - state_e       : timer FSM states (IDLE=00, RUN=01, PAUSE=10)
//   - DEFAULT_WIDTH : default counter/load width
//   - prescale_cnt_w: width of the prescaler phase counter for a given modulus
// -----------------------------------------------------------------------------
package countdown_timer_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  // A modulus of 1 still needs a 1-bit counter so the port widths stay legal.
  function automatic int prescale_cnt_w(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/countdown_timer_8bit_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_8bit_if
// Control/status bundle of the countdown timer.
//   master : LOAD, LOAD_VAL, START, STOP, EN, AUTO_RELOAD out; Q_OUT, BUSY,
//            DONE, ZERO in
//   slave  : the timer itself (directions mirrored)
// -----------------------------------------------------------------------------
interface countdown_timer_8bit_if
  import countdown_timer_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic             START;
  logic             STOP;
  logic             EN;
  logic             AUTO_RELOAD;
  logic [WIDTH-1:0] Q_OUT;
  logic             BUSY;
  logic             DONE;
  logic             ZERO;

  modport master (
    output LOAD, LOAD_VAL, START, STOP, EN, AUTO_RELOAD,
    input  Q_OUT, BUSY, DONE, ZERO
  );

  modport slave (
    input  LOAD, LOAD_VAL, START, STOP, EN, AUTO_RELOAD,
    output Q_OUT, BUSY, DONE, ZERO
  );

endinterface

// File: rtl/countdown_timer_8bit_prescale_tick.sv
// -----------------------------------------------------------------------------
// prescale_tick
// PRESCALE-modulus phase counter producing the decrement tick of the timer.
//   CLK   in  clock, rising edge
//   CLR_N in  synchronous active-low reset
//   EN    in  advance enable
//   CLEAR in  force phase back to 0 (takes precedence over counting)
//   RUN   in  counting allowed; when low the phase is held
//   TICK  out combinational, high on the edge where the phase wraps
// -----------------------------------------------------------------------------
module prescale_tick
  import countdown_timer_8bit_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic EN,
  input  logic CLEAR,
  input  logic RUN,
  output logic TICK
);

  localparam int                CNT_W = prescale_cnt_w(PRESCALE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // With PRESCALE=1 the phase is pinned at 0 == LAST, so TICK follows EN.
  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = cnt_q;
    if (CLEAR) begin
      cnt_d = '0;
    end else if (RUN && EN) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign TICK = RUN && EN && !CLEAR && wrap;

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_8bit.sv
// -----------------------------------------------------------------------------
// countdown_timer_8bit
// Loadable down-counter with prescaler, one-shot / auto-reload and pause.
//   CLK   in  clock, rising edge
//   CLR_N in  synchronous active-low reset
//   tmr   slave modport of countdown_timer_8bit_if:
//     LOAD/LOAD_VAL  load count and reload register, abort any run
//     START          start from IDLE (only if count != 0) / resume from PAUSE
//     STOP           pause a run (wins over START)
//     EN             prescaler advance enable
//     AUTO_RELOAD    reload and keep running at terminal count
//     Q_OUT          registered count
//     BUSY           high in RUN or PAUSE
//     DONE           registered one-cycle pulse at terminal count
//     ZERO           combinational Q_OUT == 0
// Edge priority: CLR_N > LOAD > STOP > START > count.
// -----------------------------------------------------------------------------
module countdown_timer_8bit
  import countdown_timer_8bit_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input logic                  CLK,
  input logic                  CLR_N,
  countdown_timer_8bit_if.slave tmr
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             tick;
  logic             presc_run;

  // The prescaler only advances while actually running; a STOP edge freezes
  // the phase so a later resume continues mid-period.
  assign presc_run = (state_q == ST_RUN) && !tmr.STOP;

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .EN    (tmr.EN),
    .CLEAR (tmr.LOAD),
    .RUN   (presc_run),
    .TICK  (tick)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (tmr.LOAD) begin
      q_d      = tmr.LOAD_VAL;
      reload_d = tmr.LOAD_VAL;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Starting an empty counter is meaningless: ignored, no DONE.
          if (tmr.START && !tmr.STOP && (q_q != '0)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tmr.STOP) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (q_q > WIDTH'(1)) begin
              q_d = q_q - WIDTH'(1);
            end else begin
              done_d = 1'b1;
              if (tmr.AUTO_RELOAD) begin
                q_d = reload_q;
              end else begin
                q_d     = '0;
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (tmr.START && !tmr.STOP) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign tmr.Q_OUT = q_q;
  assign tmr.BUSY  = (state_q != ST_IDLE);
  assign tmr.DONE  = done_q;
  assign tmr.ZERO  = (q_q == '0);

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer_8bit
// Drives a PRESCALE=1 and a PRESCALE=4 instance with identical inputs.
// Directed scenarios check against hand-derived constants; the random
// scenario checks both instances every cycle against a rule-level model.
// -----------------------------------------------------------------------------
module tb_countdown_timer_8bit;

  logic       clk = 1'b0;
  logic       clr_n, load, start, stop, en, auto_rl;
  logic [7:0] load_val;

  always #5 clk = ~clk;

  countdown_timer_8bit_if #(.WIDTH(8)) if0 ();
  countdown_timer_8bit_if #(.WIDTH(8)) if1 ();

  assign if0.LOAD = load;  assign if0.LOAD_VAL = load_val; assign if0.START = start;
  assign if0.STOP = stop;  assign if0.EN = en;             assign if0.AUTO_RELOAD = auto_rl;
  assign if1.LOAD = load;  assign if1.LOAD_VAL = load_val; assign if1.START = start;
  assign if1.STOP = stop;  assign if1.EN = en;             assign if1.AUTO_RELOAD = auto_rl;

  countdown_timer_8bit #(.WIDTH(8), .PRESCALE(1)) dut0 (.CLK(clk), .CLR_N(clr_n), .tmr(if0));
  countdown_timer_8bit #(.WIDTH(8), .PRESCALE(4)) dut1 (.CLK(clk), .CLR_N(clr_n), .tmr(if1));

  int checks = 0;
  int errors = 0;

  // Rule-level model: count value, reload value, enabled cycles into the
  // current prescale period, running / paused flags, DONE pulse.
  int m_q[2], m_rel[2], m_pre[2];
  bit m_run[2], m_pause[2], m_done[2];

  function automatic int ps(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic model_edge(input int k);
    m_done[k] = 1'b0;
    if (!clr_n) begin
      m_q[k] = 0; m_rel[k] = 0; m_pre[k] = 0; m_run[k] = 0; m_pause[k] = 0;
    end else if (load) begin
      m_q[k] = load_val; m_rel[k] = load_val; m_pre[k] = 0; m_run[k] = 0; m_pause[k] = 0;
    end else if (m_run[k] && stop) begin
      m_run[k] = 0; m_pause[k] = 1;
    end else if (!m_run[k] && start && !stop && (m_pause[k] || m_q[k] != 0)) begin
      m_run[k] = 1; m_pause[k] = 0;
    end else if (m_run[k] && en) begin
      if (m_pre[k] + 1 == ps(k)) begin
        m_pre[k] = 0;
        if (m_q[k] > 1) m_q[k] = m_q[k] - 1;
        else begin
          m_done[k] = 1'b1;
          if (auto_rl) m_q[k] = m_rel[k];
          else begin m_q[k] = 0; m_run[k] = 0; end
        end
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
  endtask

  task automatic quiet();
    load = 0; start = 0; stop = 0; en = 1; clr_n = 1;
  endtask

  task automatic test_reset();
    clr_n = 0; load = 0; load_val = 0; start = 0; stop = 0; en = 0; auto_rl = 0;
    step(); step();
    checks++; if (if0.Q_OUT !== 8'd0 || if1.Q_OUT !== 8'd0) begin errors++; $display("FAIL reset_q got %0d/%0d want 0", if0.Q_OUT, if1.Q_OUT); end
    checks++; if (if0.BUSY !== 1'b0 || if1.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 0", if0.BUSY, if1.BUSY); end
    checks++; if (if0.DONE !== 1'b0 || if0.ZERO !== 1'b1) begin errors++; $display("FAIL reset_done_zero got %b/%b want 0/1", if0.DONE, if0.ZERO); end
  endtask

  task automatic test_one_shot();
    quiet(); auto_rl = 0;
    load = 1; load_val = 8'd5; step(); load = 0;
    start = 1; step(); start = 0;
    checks++; if (if0.Q_OUT !== 8'd5 || if0.BUSY !== 1'b1) begin errors++; $display("FAIL oneshot_start q=%0d busy=%b want 5/1", if0.Q_OUT, if0.BUSY); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if0.Q_OUT !== 8'(4 - i) || if0.DONE !== (i == 4) || if0.BUSY !== (i != 4)) begin
        errors++; $display("FAIL oneshot_seq i=%0d q=%0d done=%b busy=%b want %0d/%b/%b", i, if0.Q_OUT, if0.DONE, if0.BUSY, 4 - i, i == 4, i != 4);
      end
    end
    step();
    checks++; if (if0.DONE !== 1'b0 || if0.ZERO !== 1'b1 || if0.Q_OUT !== 8'd0) begin errors++; $display("FAIL oneshot_after done=%b zero=%b q=%0d want 0/1/0", if0.DONE, if0.ZERO, if0.Q_OUT); end
  endtask

  task automatic test_auto_reload();
    int pulses;
    quiet(); auto_rl = 1; pulses = 0;
    load = 1; load_val = 8'd3; step(); load = 0;
    start = 1; step(); start = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (if0.DONE === 1'b1) pulses++;
      checks++;
      if (if0.Q_OUT !== 8'(3 - (i % 3)) || if0.DONE !== (i % 3 == 0) || if0.BUSY !== 1'b1) begin
        errors++; $display("FAIL autoreload i=%0d q=%0d done=%b busy=%b want %0d/%b/1", i, if0.Q_OUT, if0.DONE, if0.BUSY, 3 - (i % 3), i % 3 == 0);
      end
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL autoreload_pulses got %0d want 4", pulses); end
    auto_rl = 0;
  endtask

  task automatic test_pause();
    int bad;
    quiet(); bad = 0;
    load = 1; load_val = 8'd8; step(); load = 0;
    start = 1; step(); start = 0;
    repeat (4) step();
    checks++; if (if0.Q_OUT !== 8'd4) begin errors++; $display("FAIL pause_pre q=%0d want 4", if0.Q_OUT); end
    stop = 1; step(); stop = 0;
    repeat (10) begin step(); if (if0.Q_OUT !== 8'd4 || if0.BUSY !== 1'b1) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pause_hold bad_cycles=%0d want 0 (q=%0d busy=%b)", bad, if0.Q_OUT, if0.BUSY); end
    start = 1; step(); start = 0;
    step();
    checks++; if (if0.Q_OUT !== 8'd3 || if0.BUSY !== 1'b1) begin errors++; $display("FAIL pause_resume q=%0d busy=%b want 3/1", if0.Q_OUT, if0.BUSY); end
    stop = 1; step();
    start = 1; step(); start = 0; stop = 0;
    repeat (3) step();
    checks++; if (if0.Q_OUT !== 8'd3 || if0.BUSY !== 1'b1) begin errors++; $display("FAIL pause_startstop q=%0d busy=%b want 3/1", if0.Q_OUT, if0.BUSY); end
  endtask

  task automatic test_prescale();
    int cnt;
    quiet();
    load = 1; load_val = 8'd2; step(); load = 0;
    start = 1; step(); start = 0;
    cnt = 0;
    while (if1.DONE !== 1'b1 && cnt < 40) begin step(); cnt++; end
    checks++; if (cnt !== 8) begin errors++; $display("FAIL prescale_period got %0d want 8", cnt); end
    checks++; if (if1.BUSY !== 1'b0 || if1.Q_OUT !== 8'd0) begin errors++; $display("FAIL prescale_end busy=%b q=%0d want 0/0", if1.BUSY, if1.Q_OUT); end
    load = 1; step(); load = 0;
    start = 1; step(); start = 0;
    cnt = 0;
    repeat (3) begin step(); cnt++; end
    en = 0;
    repeat (5) begin step(); cnt++; end
    checks++; if (if1.Q_OUT !== 8'd2 || if1.BUSY !== 1'b1) begin errors++; $display("FAIL prescale_hold q=%0d busy=%b want 2/1", if1.Q_OUT, if1.BUSY); end
    en = 1;
    while (if1.DONE !== 1'b1 && cnt < 60) begin step(); cnt++; end
    checks++; if (cnt !== 13) begin errors++; $display("FAIL prescale_stretch got %0d want 13", cnt); end
  endtask

  task automatic test_load_abort();
    quiet();
    load = 1; load_val = 8'd10; step(); load = 0;
    start = 1; step(); start = 0;
    repeat (4) step();
    checks++; if (if0.Q_OUT !== 8'd6) begin errors++; $display("FAIL abort_pre q=%0d want 6", if0.Q_OUT); end
    load = 1; load_val = 8'd9; step(); load = 0;
    checks++; if (if0.Q_OUT !== 8'd9 || if0.BUSY !== 1'b0 || if0.DONE !== 1'b0) begin errors++; $display("FAIL abort_load q=%0d busy=%b done=%b want 9/0/0", if0.Q_OUT, if0.BUSY, if0.DONE); end
    step();
    checks++; if (if0.Q_OUT !== 8'd9) begin errors++; $display("FAIL abort_idle q=%0d want 9", if0.Q_OUT); end
    load = 1; load_val = 8'd0; step(); load = 0;
    start = 1; step(); start = 0;
    checks++; if (if0.BUSY !== 1'b0 || if0.DONE !== 1'b0 || if0.ZERO !== 1'b1) begin errors++; $display("FAIL zero_start busy=%b done=%b zero=%b want 0/0/1", if0.BUSY, if0.DONE, if0.ZERO); end
    step();
    checks++; if (if0.DONE !== 1'b0 || if0.BUSY !== 1'b0) begin errors++; $display("FAIL zero_start_after done=%b busy=%b want 0/0", if0.DONE, if0.BUSY); end
  endtask

  task automatic test_clear();
    quiet();
    load = 1; load_val = 8'd10; step(); load = 0;
    start = 1; step(); start = 0;
    repeat (3) step();
    checks++; if (if0.Q_OUT !== 8'd7) begin errors++; $display("FAIL clear_pre q=%0d want 7", if0.Q_OUT); end
    clr_n = 0; step(); clr_n = 1;
    checks++; if (if0.Q_OUT !== 8'd0 || if0.BUSY !== 1'b0 || if0.DONE !== 1'b0) begin errors++; $display("FAIL clear q=%0d busy=%b done=%b want 0/0/0", if0.Q_OUT, if0.BUSY, if0.DONE); end
    start = 1; step(); start = 0;
    checks++; if (if0.BUSY !== 1'b0 || if0.Q_OUT !== 8'd0) begin errors++; $display("FAIL clear_start busy=%b q=%0d want 0/0", if0.BUSY, if0.Q_OUT); end
  endtask

  task automatic test_random();
    logic [7:0] oq;
    logic       ob, od, oz;
    quiet(); clr_n = 0; step(); clr_n = 1;
    for (int n = 0; n < 600; n++) begin
      clr_n    = ($urandom % 100) != 0;
      load     = ($urandom % 20) == 0;
      load_val = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom % 6);
      start    = ($urandom % 4) == 0;
      stop     = ($urandom % 10) == 0;
      en       = ($urandom % 5) != 0;
      if (($urandom % 30) == 0) auto_rl = ~auto_rl;
      step();
      for (int k = 0; k < 2; k++) begin
        oq = (k == 0) ? if0.Q_OUT : if1.Q_OUT;
        ob = (k == 0) ? if0.BUSY  : if1.BUSY;
        od = (k == 0) ? if0.DONE  : if1.DONE;
        oz = (k == 0) ? if0.ZERO  : if1.ZERO;
        checks++;
        if (oq !== 8'(m_q[k]) || ob !== (m_run[k] || m_pause[k]) || od !== m_done[k] || oz !== (m_q[k] == 0)) begin
          errors++;
          $display("FAIL random n=%0d inst=%0d q=%0d busy=%b done=%b zero=%b want %0d/%b/%b/%b",
                   n, k, oq, ob, od, oz, m_q[k], m_run[k] || m_pause[k], m_done[k], m_q[k] == 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_prescale();
    test_load_abort();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
